// File: rtl/dpll_phase_ctrl_if.sv
`default_nettype none
// =====================================================================
// Module : dpll_phase_ctrl_if
// Desc   : Control/status bundle between the DPLL loop controller and its
//          user. Adds step2 when DPLL_STEP2_EN is defined.
// Rev    : 1.0
// =====================================================================
interface dpll_phase_ctrl_if;
  logic en;
  logic pd_valid;
  logic early;
  logic late;
  logic ahead;
  logic behind;
  logic bit_stb;
  logic locked;
`ifdef DPLL_STEP2_EN
  logic step2;

  modport master (
    output en, pd_valid, early, late,
    input  ahead, behind, bit_stb, locked, step2
  );

  modport slave (
    input  en, pd_valid, early, late,
    output ahead, behind, bit_stb, locked, step2
  );
`else
  modport master (
    output en, pd_valid, early, late,
    input  ahead, behind, bit_stb, locked
  );

  modport slave (
    input  en, pd_valid, early, late,
    output ahead, behind, bit_stb, locked
  );
`endif
endinterface
`default_nettype wire

// File: rtl/dpll_phase_ctrl.sv
`default_nettype none
// =====================================================================
// Module : dpll_phase_ctrl
// Desc   : Receive DPLL loop controller: early/late vote filter, one-period
//          ahead/behind correction, bit-period divider and lock detect.
//          DPLL_STEP2_EN enables doubled (+/-2) corrections with step2 flag.
// Rev    : 1.0
// =====================================================================
module dpll_phase_ctrl #(
  parameter int NOM_DIV  = 8,
  parameter int CNT_W    = 4,
  parameter int VOTE_W   = 5,
  parameter int VOTE_TH  = 4,
  parameter int LOCK_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  dpll_phase_ctrl_if.slave ctrl
);

  localparam int SAT   = (1 << (VOTE_W - 1)) - 1;
  localparam int NSAT  = -SAT;
  localparam int NTH   = -VOTE_TH;
  localparam int Q_W   = $clog2(LOCK_CNT + 1);
  localparam int L_NOM = NOM_DIV - 1;
  localparam int L_LNG = NOM_DIV;
  localparam int L_SHT = NOM_DIV - 2;
  localparam int ONE   = 1;

  localparam logic signed [VOTE_W-1:0] ACC_MAX = SAT[VOTE_W-1:0];
  localparam logic signed [VOTE_W-1:0] ACC_MIN = NSAT[VOTE_W-1:0];
  localparam logic signed [VOTE_W-1:0] ACC_ONE = ONE[VOTE_W-1:0];
  localparam logic signed [VOTE_W-1:0] TH_POS  = VOTE_TH[VOTE_W-1:0];
  localparam logic signed [VOTE_W-1:0] TH_NEG  = NTH[VOTE_W-1:0];

  localparam logic [CNT_W-1:0] LAST_NOM = L_NOM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LAST_LNG = L_LNG[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LAST_SHT = L_SHT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = ONE[CNT_W-1:0];

  localparam logic [Q_W-1:0] LOCK_Q   = LOCK_CNT[Q_W-1:0];
  localparam logic [Q_W-1:0] QUIET_ONE = ONE[Q_W-1:0];

`ifdef DPLL_STEP2_EN
  // Doubling threshold is clipped so it stays reachable by a saturated accumulator.
  localparam int TH2    = (2 * VOTE_TH > SAT) ? SAT : 2 * VOTE_TH;
  localparam int NTH2   = -TH2;
  localparam int L_LNG2 = NOM_DIV + 1;
  localparam int L_SHT2 = NOM_DIV - 3;
  localparam logic signed [VOTE_W-1:0] TH2_POS   = TH2[VOTE_W-1:0];
  localparam logic signed [VOTE_W-1:0] TH2_NEG   = NTH2[VOTE_W-1:0];
  localparam logic [CNT_W-1:0]         LAST_LNG2 = L_LNG2[CNT_W-1:0];
  localparam logic [CNT_W-1:0]         LAST_SHT2 = L_SHT2[CNT_W-1:0];
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_CORRECT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          div_cnt_q, div_cnt_d;
  logic signed [VOTE_W-1:0]  acc_q, acc_d;
  logic [Q_W-1:0]            quiet_q, quiet_d;
  logic                      ahead_q, ahead_d;
  logic                      behind_q, behind_d;
  logic                      locked_q, locked_d;
`ifdef DPLL_STEP2_EN
  logic                      step2_q, step2_d;
`endif

  logic [CNT_W-1:0]          w_last;
  logic                      w_wrap;
  logic                      w_up;
  logic                      w_dn;
  logic signed [VOTE_W-1:0]  w_acc_voted;
  logic [Q_W-1:0]            w_quiet_inc;

  // Last count of the current period, stretched or shrunk by the active correction.
  always_comb begin
    w_last = LAST_NOM;
`ifdef DPLL_STEP2_EN
    if (ahead_q)       w_last = step2_q ? LAST_LNG2 : LAST_LNG;
    else if (behind_q) w_last = step2_q ? LAST_SHT2 : LAST_SHT;
`else
    if (ahead_q)       w_last = LAST_LNG;
    else if (behind_q) w_last = LAST_SHT;
`endif
  end

  assign w_wrap = (state_q != ST_IDLE) && (div_cnt_q == w_last);
  assign w_up   = ctrl.pd_valid &  ctrl.early & ~ctrl.late;
  assign w_dn   = ctrl.pd_valid & ~ctrl.early &  ctrl.late;

  always_comb begin
    w_acc_voted = acc_q;
    if (w_up && (acc_q != ACC_MAX))      w_acc_voted = acc_q + ACC_ONE;
    else if (w_dn && (acc_q != ACC_MIN)) w_acc_voted = acc_q - ACC_ONE;
  end

  assign w_quiet_inc = (quiet_q == LOCK_Q) ? quiet_q : quiet_q + QUIET_ONE;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    acc_d     = acc_q;
    quiet_d   = quiet_q;
    ahead_d   = ahead_q;
    behind_d  = behind_q;
    locked_d  = locked_q;
`ifdef DPLL_STEP2_EN
    step2_d   = step2_q;
`endif

    if (state_q != ST_IDLE) begin
      div_cnt_d = w_wrap ? '0 : div_cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_TRACK;
      end

      ST_TRACK: begin
        // Threshold test uses the accumulator before this cycle's vote.
        if (w_wrap && (acc_q >= TH_POS)) begin
          ahead_d  = 1'b1;
          acc_d    = '0;
          quiet_d  = '0;
          locked_d = 1'b0;
          state_d  = ST_CORRECT;
`ifdef DPLL_STEP2_EN
          step2_d  = (acc_q >= TH2_POS);
`endif
        end else if (w_wrap && (acc_q <= TH_NEG)) begin
          behind_d = 1'b1;
          acc_d    = '0;
          quiet_d  = '0;
          locked_d = 1'b0;
          state_d  = ST_CORRECT;
`ifdef DPLL_STEP2_EN
          step2_d  = (acc_q <= TH2_NEG);
`endif
        end else begin
          acc_d = w_acc_voted;
          if (w_wrap) begin
            quiet_d = w_quiet_inc;
            if (w_quiet_inc == LOCK_Q) locked_d = 1'b1;
          end
        end
      end

      ST_CORRECT: begin
        if (w_wrap) begin
          ahead_d  = 1'b0;
          behind_d = 1'b0;
          state_d  = ST_TRACK;
`ifdef DPLL_STEP2_EN
          step2_d  = 1'b0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Dropping enable clears everything exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || !ctrl.en) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      acc_q     <= '0;
      quiet_q   <= '0;
      ahead_q   <= 1'b0;
      behind_q  <= 1'b0;
      locked_q  <= 1'b0;
`ifdef DPLL_STEP2_EN
      step2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      acc_q     <= acc_d;
      quiet_q   <= quiet_d;
      ahead_q   <= ahead_d;
      behind_q  <= behind_d;
      locked_q  <= locked_d;
`ifdef DPLL_STEP2_EN
      step2_q   <= step2_d;
`endif
    end
  end

  assign ctrl.ahead   = ahead_q;
  assign ctrl.behind  = behind_q;
  assign ctrl.bit_stb = w_wrap;
  assign ctrl.locked  = locked_q;
`ifdef DPLL_STEP2_EN
  assign ctrl.step2   = step2_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpll_phase_ctrl.sv
`default_nettype none
// =====================================================================
// Module : tb_dpll_phase_ctrl
// Desc   : Directed self-checking bench for dpll_phase_ctrl.
// Rev    : 1.0
// =====================================================================
module tb_dpll_phase_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   p;

  always #5 clk = ~clk;

  dpll_phase_ctrl_if bus ();
  dpll_phase_ctrl_if sbus ();

  dpll_phase_ctrl #(
    .NOM_DIV(8), .CNT_W(4), .VOTE_W(5), .VOTE_TH(4), .LOCK_CNT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus.slave)
  );

  // Large divide and maximal threshold so the accumulator can reach saturation.
  dpll_phase_ctrl #(
    .NOM_DIV(14), .CNT_W(5), .VOTE_W(5), .VOTE_TH(15), .LOCK_CNT(16)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .ctrl(sbus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_stb(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((bus.bit_stb !== 1'b1) && (n < 64));
  endtask

  task automatic vote(input logic e, input logic l, input int n);
    bus.pd_valid = 1'b1;
    bus.early    = e;
    bus.late     = l;
    repeat (n) tick();
    bus.pd_valid = 1'b0;
    bus.early    = 1'b0;
    bus.late     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;  bus.pd_valid = 1'b0;  bus.early = 1'b0;  bus.late = 1'b0;
    sbus.en = 1'b0; sbus.pd_valid = 1'b0; sbus.early = 1'b0; sbus.late = 1'b0;
    tick();
    tick();
    chk("rst_ahead",  bus.ahead,   1'b0);
    chk("rst_behind", bus.behind,  1'b0);
    chk("rst_stb",    bus.bit_stb, 1'b0);
    chk("rst_locked", bus.locked,  1'b0);

    // Nominal periods and lock acquisition
    rst = 1'b0;
    bus.en = 1'b1;
    next_stb(p);
    chk("first_stb", p, 8);
    for (int i = 1; i < 16; i++) begin
      next_stb(p);
      chk("nom_period", p, 8);
      chk("nom_corr", {bus.ahead, bus.behind}, 2'b00);
    end
    chk("lock_pre", bus.locked, 1'b0);
    tick();
    chk("lock_rise", bus.locked, 1'b1);

    // Four early votes -> one lengthened period
    vote(1'b1, 1'b0, 4);
    next_stb(p);
    chk("early_wait", p, 3);
    chk("ahead_pre", bus.ahead, 1'b0);
    tick();
    chk("ahead_set", bus.ahead, 1'b1);
    chk("lock_drop", bus.locked, 1'b0);
    next_stb(p);
    chk("ahead_period", p + 1, 9);
    chk("ahead_hold", bus.ahead, 1'b1);
    tick();
    chk("ahead_clr", bus.ahead, 1'b0);
    next_stb(p);
    chk("post_corr_period", p + 1, 8);
    tick();
    chk("acc_cleared", {bus.ahead, bus.behind}, 2'b00);

    // Four late votes -> one shortened period
    vote(1'b0, 1'b1, 4);
    next_stb(p);
    tick();
    chk("behind_set", bus.behind, 1'b1);
    chk("behind_no_ahead", bus.ahead, 1'b0);
    next_stb(p);
    chk("behind_period", p + 1, 7);
    tick();
    chk("behind_clr", bus.behind, 1'b0);

    // Simultaneous early+late votes cancel
    vote(1'b1, 1'b1, 10);
    next_stb(p);
    chk("both_wait", p, 5);
    tick();
    chk("both_nocorr", {bus.ahead, bus.behind}, 2'b00);

    // Vote on the firing wrap and votes during CORRECT are both discarded
    vote(1'b1, 1'b0, 4);
    next_stb(p);
    vote(1'b1, 1'b0, 1);
    chk("wrapvote_ahead", bus.ahead, 1'b1);
    vote(1'b1, 1'b0, 4);
    next_stb(p);
    chk("corr_votes_period", p + 5, 9);
    tick();
    vote(1'b1, 1'b0, 3);
    next_stb(p);
    tick();
    chk("wrapvote_discard", {bus.ahead, bus.behind}, 2'b00);

    // Drop enable in the middle of a correction
    vote(1'b1, 1'b0, 1);
    next_stb(p);
    tick();
    chk("corr2_ahead", bus.ahead, 1'b1);
    repeat (4) tick();
    bus.en = 1'b0;
    tick();
    chk("en_ahead",  bus.ahead,   1'b0);
    chk("en_behind", bus.behind,  1'b0);
    chk("en_stb",    bus.bit_stb, 1'b0);
    chk("en_locked", bus.locked,  1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_stb", bus.bit_stb, 1'b0);
    end
    bus.en = 1'b1;
    next_stb(p);
    chk("reen_first", p, 8);
    next_stb(p);
    chk("reen_period", p, 8);

    // Reset in the middle of a correction
    tick();
    vote(1'b0, 1'b1, 4);
    next_stb(p);
    tick();
    chk("corr3_behind", bus.behind, 1'b1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rstm_ahead",  bus.ahead,   1'b0);
    chk("rstm_behind", bus.behind,  1'b0);
    chk("rstm_stb",    bus.bit_stb, 1'b0);
    chk("rstm_locked", bus.locked,  1'b0);
    rst = 1'b0;
    next_stb(p);
    chk("rst_resume", p, 8);

    // Eight early votes: doubled step only when the option is built in
    vote(1'b1, 1'b0, 8);
    chk("s2_wrap", bus.bit_stb, 1'b1);
    tick();
    chk("s2_ahead", bus.ahead, 1'b1);
`ifdef DPLL_STEP2_EN
    chk("s2_flag", bus.step2, 1'b1);
    next_stb(p);
    chk("s2_period", p + 1, 10);
`else
    next_stb(p);
    chk("s1_period", p + 1, 9);
`endif
    tick();
    chk("s2_clr", bus.ahead, 1'b0);
`ifdef DPLL_STEP2_EN
    chk("s2_flag_clr", bus.step2, 1'b0);
`endif

    // Saturation: 20 early votes must clamp at +15, not wrap negative
    sbus.en = 1'b1;
    tick();
    sbus.pd_valid = 1'b1;
    sbus.early    = 1'b1;
    repeat (20) tick();
    sbus.pd_valid = 1'b0;
    sbus.early    = 1'b0;
    repeat (7) tick();
    chk("sat_stb", sbus.bit_stb, 1'b1);
    chk("sat_pre", sbus.ahead, 1'b0);
    tick();
    chk("sat_ahead",  sbus.ahead,  1'b1);
    chk("sat_behind", sbus.behind, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpll_phase_ctrl.md
Name: dpll_phase_ctrl

Overview:
Loop controller for the receive digital PLL. It filters per-bit early/late votes from the phase detector into a saturating vote accumulator. When the accumulator crosses threshold it issues a one-bit-period ahead/behind correction, which drives the divide-count selector (N+1 / N-1). It also runs the bit-period divider that the correction acts on, producing the recovered bit strobe and a lock flag.

Parameters:
NOM_DIV, 8, nominal clocks per bit period (equals divide-selector N); legal 4..14
CNT_W, 4, divider counter width; must hold NOM_DIV+1 (NOM_DIV+2 with DPLL_STEP2_EN)
VOTE_W, 5, signed vote accumulator width
VOTE_TH, 4, correction threshold magnitude; 1..2^(VOTE_W-1)-1
LOCK_CNT, 16, consecutive correction-free periods required to assert locked

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  loop enable; 0 holds block in IDLE
pd_valid  in  1  one-cycle qualifier for early/late
early  in  1  phase detector: sampling early (period must lengthen)
late  in  1  phase detector: sampling late (period must shorten)
ahead  out  1  registered; high for exactly one lengthened period (to divide selector)
behind  out  1  registered; high for exactly one shortened period
bit_stb  out  1  one-cycle pulse on last clock of each period
locked  out  1  registered lock indicator

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, div_cnt=0, acc=0, quiet_cnt=0; ahead=behind=bit_stb=locked=0. Reset mid-correction aborts it immediately; no partial period is reported.
- IDLE: all registers held at reset values. en=1 -> TRACK next cycle, div_cnt starts at 0. en=0 in any state -> IDLE next cycle; same clear as reset.
- Period length P = NOM_DIV+1 if ahead, NOM_DIV-1 if behind, otherwise NOM_DIV. div_cnt counts 0..P-1 and wraps to 0. bit_stb=1 combinationally decoded in the cycle div_cnt==P-1 ("wrap cycle") while not IDLE.
- Vote: on pd_valid, early&!late -> acc+1; late&!early -> acc-1; both or neither -> no change. Saturate at +/-(2^(VOTE_W-1)-1); never wrap.
- TRACK, at wrap cycle, uses acc value before this cycle's vote:
  - acc >= VOTE_TH -> ahead<=1, acc<=0, go CORRECT.
  - acc <= -VOTE_TH -> behind<=1, acc<=0, go CORRECT.
  - When either correction fires, that cycle's vote is discarded. Otherwise the vote is applied normally and the state stays TRACK.
- CORRECT: lasts exactly one period of length P (P uses the already-set ahead/behind). pd_valid votes are ignored. At its wrap cycle: ahead=behind=0, go TRACK. ahead and behind are never both 1.
- Lock:
  - quiet_cnt increments (saturating) at each TRACK wrap with no correction. It clears to 0 on any correction.
  - locked<=1 when quiet_cnt reaches LOCK_CNT. locked<=0 on the cycle a correction fires.
- Latency: a threshold-crossing vote affects P of the period starting after the next wrap; ahead/behind change only on a wrap-cycle edge.

Optional Feature:
- Macro: DPLL_STEP2_EN.
- Defined:
  - Adds output step2 (1 bit, reset 0).
  - At a TRACK wrap with |acc| >= 2*VOTE_TH, the correction is doubled: P = NOM_DIV+/-2 for the CORRECT period, and step2=1 alongside ahead/behind for that period.
  - 2*VOTE_TH is clipped to the saturation limit.
- Not defined: no step2 port; corrections are always +/-1.

Test Plan:
1. NOM_DIV=8, rst then en=1, no votes -> bit_stb every 8 clocks, first at clock 8 after en sampled; ahead=behind=0; locked rises at the 16th wrap.
2. Four early votes (pd_valid with early=1) within one period -> at next wrap ahead=1 for one 9-clock period, then ahead=0; acc=0; locked drops at the correction cycle.
3. Four late votes -> behind=1 for one 7-clock period. Early and late together for 10 votes -> acc unchanged, no correction.
4. 20 early votes with VOTE_W=5 -> acc saturates at +15, no wrap to negative. Vote landing on the wrap cycle that triggers a correction -> discarded, acc=0 afterwards.
5. Deassert en or assert rst mid-CORRECT (div_cnt=4) -> next cycle all outputs 0, state IDLE. Re-enable -> 8-clock periods resume from div_cnt=0.
6. DPLL_STEP2_EN, VOTE_TH=4, 8 early votes -> ahead=1, step2=1, 10-clock period. Without the macro, same stimulus -> 9-clock period.
